// File: rtl/sam_pkg.sv
// SAM microsequencer shared definitions: state encoding,
// control-bit indices, opcodes and per-state control words.
package sam_pkg;

  typedef enum logic [3:0] {
    S_RESET0  = 4'd0,
    S_FETCH0  = 4'd1,
    S_FETCH1  = 4'd2,
    S_FETCH2  = 4'd3,
    S_FETCH3  = 4'd4,
    S_DECODE  = 4'd5,
    S_BR_TAKE = 4'd6,
    S_RD1     = 4'd7,
    S_RD_WAIT = 4'd8,
    S_EX_LOAD = 4'd9,
    S_EX_ADD  = 4'd10,
    S_ST0     = 4'd11,
    S_ST1     = 4'd12,
    S_ST_WAIT = 4'd13
  } state_t;

  localparam int B_PC_ABUS   = 21;
  localparam int B_IR_ABUS   = 20;
  localparam int B_MBR_ABUS  = 19;
  localparam int B_RBUS_AC   = 18;
  localparam int B_AC_ALUA   = 17;
  localparam int B_MBUS_ALUB = 16;
  localparam int B_ALU_ADD   = 15;
  localparam int B_ALU_PASSB = 14;
  localparam int B_MAR_ADDR  = 13;
  localparam int B_MBR_DATA  = 12;
  localparam int B_ABUS_IR   = 11;
  localparam int B_ABUS_MAR  = 10;
  localparam int B_DATA_MBR  = 9;
  localparam int B_RBUS_MBR  = 8;
  localparam int B_MBR_MBUS  = 7;
  localparam int B_PC_CLR    = 6;
  localparam int B_PC_INC    = 5;
  localparam int B_ABUS_PC   = 4;
  localparam int B_RW        = 3;
  localparam int B_REQ       = 2;
  localparam int B_AC_RBUS   = 1;
  localparam int B_ALU_RBUS  = 0;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_BRN   = 2'b11;

  function automatic logic [21:0] cb(input int i);
    return 22'(1) << i;
  endfunction

  localparam logic [21:0] W_RESET0 =
    cb(B_PC_CLR) | cb(B_RW);
  localparam logic [21:0] W_FETCH0 =
    cb(B_PC_ABUS) | cb(B_ABUS_MAR) | cb(B_RW);
  localparam logic [21:0] W_FETCH1 =
    cb(B_MAR_ADDR) | cb(B_RW) | cb(B_REQ);
  localparam logic [21:0] W_FETCH2 =
    cb(B_MAR_ADDR) | cb(B_DATA_MBR) |
    cb(B_RW) | cb(B_REQ);
  localparam logic [21:0] W_FETCH3 =
    cb(B_MBR_ABUS) | cb(B_ABUS_IR) |
    cb(B_PC_INC) | cb(B_RW);
  localparam logic [21:0] W_DECODE =
    cb(B_IR_ABUS) | cb(B_ABUS_MAR) | cb(B_RW);
  localparam logic [21:0] W_BR_TAKE =
    cb(B_IR_ABUS) | cb(B_ABUS_PC) | cb(B_RW);
  localparam logic [21:0] W_RD1 = W_FETCH1;
  localparam logic [21:0] W_RD_WAIT = W_FETCH2;
  localparam logic [21:0] W_EX_LOAD =
    cb(B_RBUS_AC) | cb(B_MBUS_ALUB) |
    cb(B_ALU_PASSB) | cb(B_MBR_MBUS) |
    cb(B_RW) | cb(B_ALU_RBUS);
  localparam logic [21:0] W_EX_ADD =
    cb(B_RBUS_AC) | cb(B_AC_ALUA) |
    cb(B_MBUS_ALUB) | cb(B_ALU_ADD) |
    cb(B_MBR_MBUS) | cb(B_RW) |
    cb(B_ALU_RBUS);
  localparam logic [21:0] W_ST0 =
    cb(B_RBUS_MBR) | cb(B_RW) | cb(B_AC_RBUS);
  localparam logic [21:0] W_ST1 =
    cb(B_MAR_ADDR) | cb(B_MBR_DATA) | cb(B_REQ);
  localparam logic [21:0] W_ST_WAIT = W_ST1;

endpackage

// File: rtl/sam_ucode_rom.sv
// State to control-word lookup (pure combinational).
// Ports: state (in), b (22-bit control word out).
module sam_ucode_rom
  import sam_pkg::*;
(
  input  state_t      state,
  output logic [21:0] b
);

  always_comb begin
    b = W_RESET0;
    case (state)
      S_RESET0:  b = W_RESET0;
      S_FETCH0:  b = W_FETCH0;
      S_FETCH1:  b = W_FETCH1;
      S_FETCH2:  b = W_FETCH2;
      S_FETCH3:  b = W_FETCH3;
      S_DECODE:  b = W_DECODE;
      S_BR_TAKE: b = W_BR_TAKE;
      S_RD1:     b = W_RD1;
      S_RD_WAIT: b = W_RD_WAIT;
      S_EX_LOAD: b = W_EX_LOAD;
      S_EX_ADD:  b = W_EX_ADD;
      S_ST0:     b = W_ST0;
      S_ST1:     b = W_ST1;
      S_ST_WAIT: b = W_ST_WAIT;
      default:   b = W_RESET0;
    endcase
  end

endmodule

// File: rtl/sam_controller.sv
// SAM hardwired microsequencer: state register + next-state.
// Ports: clk, rst_n, WAIT, ir_15, ac_15, ir_14 in; b out.
module sam_controller
  import sam_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        WAIT,
  input  logic        ir_15,
  input  logic        ac_15,
  input  logic        ir_14,
  output logic [21:0] b
);

  state_t     state;
  state_t     state_nx;
  logic [1:0] op;

  assign op = {ir_15, ir_14};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RESET0;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = S_RESET0;
    case (state)
      S_RESET0:  state_nx = S_FETCH0;
      S_FETCH0:  state_nx = S_FETCH1;
      S_FETCH1:  state_nx = S_FETCH2;
      S_FETCH2:  state_nx = WAIT ? S_FETCH2 : S_FETCH3;
      S_FETCH3:  state_nx = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (op == OP_LOAD),
          (op == OP_ADD):   state_nx = S_RD1;
          (op == OP_STORE): state_nx = S_ST0;
          (op == OP_BRN):
            state_nx = ac_15 ? S_BR_TAKE : S_FETCH0;
          default:          state_nx = S_FETCH0;
        endcase
      end
      S_BR_TAKE: state_nx = S_FETCH0;
      S_RD1:     state_nx = S_RD_WAIT;
      S_RD_WAIT: begin
        if (WAIT)              state_nx = S_RD_WAIT;
        else if (op == OP_ADD) state_nx = S_EX_ADD;
        else                   state_nx = S_EX_LOAD;
      end
      S_EX_LOAD: state_nx = S_FETCH0;
      S_EX_ADD:  state_nx = S_FETCH0;
      S_ST0:     state_nx = S_ST1;
      S_ST1:     state_nx = S_ST_WAIT;
      S_ST_WAIT: state_nx = WAIT ? S_ST_WAIT : S_FETCH0;
      default:   state_nx = S_RESET0;
    endcase
  end

  sam_ucode_rom u_rom (
    .state (state),
    .b     (b)
  );

endmodule

// File: tb/tb_sam_controller.sv
// Randomized bench: per-instruction expected control-word
// sequences checked each falling edge against the DUT.
module tb_sam_controller;

  localparam logic [21:0] X_RST = 22'h000048;
  localparam logic [21:0] X_F0  = 22'h200408;
  localparam logic [21:0] X_F1  = 22'h00200C;
  localparam logic [21:0] X_F2  = 22'h00220C;
  localparam logic [21:0] X_F3  = 22'h080828;
  localparam logic [21:0] X_DEC = 22'h100408;
  localparam logic [21:0] X_BR  = 22'h100018;
  localparam logic [21:0] X_EXL = 22'h054089;
  localparam logic [21:0] X_EXA = 22'h078089;
  localparam logic [21:0] X_ST0 = 22'h00010A;
  localparam logic [21:0] X_ST1 = 22'h003004;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        WAIT = 1'b0;
  logic        ir_15 = 1'b0;
  logic        ir_14 = 1'b0;
  logic        ac_15 = 1'b0;
  logic [21:0] b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sam_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .WAIT  (WAIT),
    .ir_15 (ir_15),
    .ac_15 (ac_15),
    .ir_14 (ir_14),
    .b     (b)
  );

  task automatic chk(input string tag,
                     input logic [21:0] got,
                     input logic [21:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %06h expected %06h",
               tag, got, exp);
    end
  endtask

  // Entered at a falling edge: check the word for this
  // cycle, drive inputs for the next rising edge.
  task automatic step(input string tag,
                      input logic [21:0] exp,
                      input logic w,
                      input logic [1:0] op,
                      input logic ac);
    #1;
    chk(tag, b, exp);
    WAIT  = w;
    {ir_15, ir_14} = op;
    ac_15 = ac;
    @(negedge clk);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] rop();
    return 2'($urandom_range(0, 3));
  endfunction

  // Opcode/ac_15 are junk until FETCH3, WAIT is junk
  // outside wait states; the DUT must ignore both.
  task automatic run_instr(input logic [1:0] op,
                           input logic ac,
                           input int nf,
                           input int nd);
    step("fetch0", X_F0, rb(), rop(), rb());
    step("fetch1", X_F1, rb(), rop(), rb());
    for (int i = 0; i < nf; i++)
      step("fetch2_w", X_F2, 1'b1, rop(), rb());
    step("fetch2", X_F2, 1'b0, rop(), rb());
    step("fetch3", X_F3, rb(), op, ac);
    step("decode", X_DEC, rb(), op, ac);
    case (op)
      2'b11: if (ac) step("br_take", X_BR, rb(), op, ac);
      2'b01: begin
        step("st0", X_ST0, rb(), op, ac);
        step("st1", X_ST1, rb(), op, ac);
        for (int i = 0; i < nd; i++)
          step("st_wait_w", X_ST1, 1'b1, op, ac);
        step("st_wait", X_ST1, 1'b0, op, ac);
      end
      default: begin
        step("rd1", X_F1, rb(), op, ac);
        for (int i = 0; i < nd; i++)
          step("rd_wait_w", X_F2, 1'b1, op, ac);
        step("rd_wait", X_F2, 1'b0, op, ac);
        step(op == 2'b00 ? "ex_load" : "ex_add",
             op == 2'b00 ? X_EXL : X_EXA,
             rb(), rop(), rb());
      end
    endcase
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk("reset_async", b, X_RST);
    @(posedge clk);
    #1 chk("reset_hold", b, X_RST);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_instr(2'b00, 1'b0, 0, 0);
    run_instr(2'b10, 1'b0, 0, 3);
    run_instr(2'b01, 1'b1, 0, 2);
    run_instr(2'b11, 1'b1, 0, 0);
    run_instr(2'b11, 1'b0, 0, 0);
    run_instr(2'b11, 1'b0, 5, 0);
    run_instr(2'b01, 1'b0, 0, 0);
    run_instr(2'b10, 1'b1, 2, 25);

    // Reset in the middle of a read access.
    step("m_fetch0", X_F0, 1'b0, 2'b00, 1'b0);
    step("m_fetch1", X_F1, 1'b0, 2'b00, 1'b0);
    step("m_fetch2", X_F2, 1'b0, 2'b00, 1'b0);
    step("m_fetch3", X_F3, 1'b0, 2'b00, 1'b0);
    step("m_decode", X_DEC, 1'b0, 2'b00, 1'b0);
    step("m_rd1", X_F1, 1'b1, 2'b00, 1'b0);
    #1 chk("m_rd_wait", b, X_F2);
    WAIT = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("mid_reset", b, X_RST);
    @(posedge clk);
    #1 chk("mid_reset_hold", b, X_RST);
    @(negedge clk);
    rst_n = 1'b1;
    WAIT  = 1'b0;
    @(negedge clk);
    run_instr(2'b00, 1'b0, 0, 0);

    for (int n = 0; n < 150; n++)
      run_instr(rop(), rb(),
                $urandom_range(0, 3) == 0 ?
                  $urandom_range(1, 6) : 0,
                $urandom_range(0, 3) == 0 ?
                  $urandom_range(1, 6) : 0);

    #1 chk("final_fetch0", b, X_F0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
